alm_mult_pipe: RTL and testbench

Parametrised, pipelined approximate logarithmic multiplier (Mitchell-style with set-one adder, SOA) with a valid/ready stream interface and a per-operand exact/approximate mode. It generalises the fixed 16-bit, single-register ALM-SOA multiplier wrapper to arbitrary operand width and SOA depth. It adds backpressure and an exact-product bypass for on-line error measurement. It sits between the operand source and the accumulator/error-statistics logic.

---
 rtl/alm_pkg.sv | 46 ++++
 rtl/alm_mult_pipe_if.sv | 25 ++
 rtl/alm_lod.sv | 20 ++
 rtl/alm_mult_pipe.sv | 109 ++++++++++
 tb/tb_alm_mult_pipe.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alm_pkg.sv
// Shared widths, leading-one decomposition and the behavioural ALM-SOA reference
// used by the pipeline's self-checks and by verification.
package alm_pkg;

    localparam int unsigned W_MAX  = 32;
    localparam int unsigned KW_MAX = 6;

    // Leading-one index and the (w-1)-bit fraction below it, right-justified in f.
    typedef struct packed {
        logic [KW_MAX-1:0] k;
        logic [W_MAX-2:0]  f;
    } lod_t;

    function automatic int unsigned kw_of(input int unsigned w);
        return $clog2(w);
    endfunction

    function automatic lod_t lod(input logic [W_MAX-1:0] a, input int unsigned w);
        lod_t r;
        r = '0;
        for (int unsigned i = 0; i < w; i++)
            if (a[i]) r.k = KW_MAX'(i);
        if (a != '0)
            r.f = (W_MAX-1)'((64'(a) ^ (64'd1 << r.k)) << (w - 1 - 32'(r.k)));
        return r;
    endfunction

    function automatic logic [63:0] alm_soa_ref(input logic [W_MAX-1:0] x,
                                                input logic [W_MAX-1:0] y,
                                                input int unsigned      w,
                                                input int unsigned      m);
        lod_t             la;
        lod_t             lb;
        logic [W_MAX-1:0] u;
        logic [63:0]      s;
        int unsigned      kk;
        if (x == '0 || y == '0) return '0;
        la = lod(x, w);
        lb = lod(y, w);
        u  = W_MAX'(la.f >> m) + W_MAX'(lb.f >> m);
        s  = ((64'(u) & ((64'd1 << (w - 1 - m)) - 64'd1)) << m) | ((64'd1 << m) - 64'd1);
        kk = 32'(la.k) + 32'(lb.k) + 32'(u[w-1-m]);
        return 64'(({64'd0, (64'd1 << (w - 1)) | s} << kk) >> (w - 1));
    endfunction

endpackage

// File: rtl/alm_mult_pipe_if.sv
// Operand/result stream bundle for alm_mult_pipe: the source/consumer drives
// through master, the multiplier sits on slave.
interface alm_mult_pipe_if #(
    parameter int unsigned W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           approx;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p_out;
    logic           p_approx;

    modport master (
        output in_valid, x, y, approx, out_ready,
        input  in_ready, out_valid, p_out, p_approx
    );

    modport slave (
        input  in_valid, x, y, approx, out_ready,
        output in_ready, out_valid, p_out, p_approx
    );
endinterface

// File: rtl/alm_lod.sv
// Leading-one detector plus normaliser: k is the leading-one index, f the bits
// below it left-aligned into a (W-1)-bit fraction.
module alm_lod #(
    parameter int unsigned W  = 16,
    parameter int unsigned KW = 4
) (
    input  logic [W-1:0]  a_i,
    output logic [KW-1:0] k_o,
    output logic [W-2:0]  f_o,
    output logic          zero_o
);
    always_comb begin
        // NOTE: k_o gets a default before the loop so no path leaves it unassigned (no latch).
        k_o = '0;
        for (int i = 0; i < W; i++)
            if (a_i[i]) k_o = KW'(i);
        f_o    = (W-1)'(a_i << (KW'(W - 1) - k_o));
        zero_o = (a_i == '0);
    end
endmodule

// File: rtl/alm_mult_pipe.sv
// Pipelined ALM-SOA / exact multiplier: operand register, LOD, SOA add, antilog
// shift into the output register, all under one global stall.
module alm_mult_pipe
    import alm_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned M = 10
) (
    input  logic           clk,
    input  logic           rst,
    alm_mult_pipe_if.slave bus
);
    localparam int unsigned  KW       = kw_of(W);
    localparam int unsigned  UW       = W - 1 - M;
    localparam logic [W-2:0] SOA_ONES = (W-1)'((64'd1 << M) - 64'd1);

    logic           advance;
    logic           v0_q, ap0_q;
    logic [W-1:0]   x0_q, y0_q;
    logic           v1_q, ap1_q, z1_q;
    logic [KW-1:0]  ka1_q, kb1_q;
    logic [UW-1:0]  fa1_q, fb1_q;
    logic [W-1:0]   x1_q, y1_q;
    logic           v2_q, ap2_q, z2_q;
    logic [W-2:0]   s2_q;
    logic [KW:0]    kk2_q;
    logic [2*W-1:0] pe2_q;
    logic           v3_q, ap3_q;
    logic [2*W-1:0] p3_q;

    logic [KW-1:0]  ka_d, kb_d;
    logic [W-2:0]   fa_d, fb_d;
    logic           za_d, zb_d;
    logic [UW:0]    u_d;
    logic [W-2:0]   s2_d;
    logic [KW:0]    kk2_d;
    logic [2*W-1:0] pe2_d;
    logic [2*W-1:0] p3_d;

    assign advance      = !v3_q || bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out_valid = v3_q;
    assign bus.p_out    = p3_q;
    assign bus.p_approx = ap3_q;

    alm_lod #(.W(W), .KW(KW)) u_lod_x (.a_i(x0_q), .k_o(ka_d), .f_o(fa_d), .zero_o(za_d));
    alm_lod #(.W(W), .KW(KW)) u_lod_y (.a_i(y0_q), .k_o(kb_d), .f_o(fb_d), .zero_o(zb_d));

    always_comb begin
        u_d   = {1'b0, fa1_q} + {1'b0, fb1_q};
        s2_d  = ((W-1)'(u_d[UW-1:0]) << M) | SOA_ONES;
        kk2_d = (KW+1)'(ka1_q) + (KW+1)'(kb1_q) + (KW+1)'(u_d[UW]);
        pe2_d = (2*W)'(x1_q) * (2*W)'(y1_q);
        p3_d  = '0;
        if (!z2_q)
            p3_d = ap2_q ? (2*W)'(((3*W-1)'({1'b1, s2_q}) << kk2_q) >> (W - 1)) : pe2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            ap3_q <= 1'b0;
            p3_q  <= '0;
        end else if (advance) begin
            v0_q  <= bus.in_valid;  // in_ready == advance, so this is the accept
            v1_q  <= v0_q;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            ap3_q <= ap2_q;
            p3_q  <= p3_d;
        end
    end

    // NOTE: datapath registers carry no reset; the stage valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (advance) begin
            x0_q  <= bus.x;
            y0_q  <= bus.y;
            ap0_q <= bus.approx;
            ka1_q <= ka_d;
            kb1_q <= kb_d;
            fa1_q <= fa_d[W-2:M];
            fb1_q <= fb_d[W-2:M];
            z1_q  <= za_d || zb_d;
            x1_q  <= x0_q;
            y1_q  <= y0_q;
            ap1_q <= ap0_q;
            s2_q  <= s2_d;
            kk2_q <= kk2_d;
            pe2_q <= pe2_d;
            z2_q  <= z1_q;
            ap2_q <= ap1_q;
        end
    end

    lod_t lx, ly;
    assign lx = lod(W_MAX'(x0_q), W);
    assign ly = lod(W_MAX'(y0_q), W);

    always @(posedge clk) begin
        if (!rst && v0_q)
            assert (KW_MAX'(ka_d) == lx.k && (W_MAX-1)'(fa_d) == lx.f &&
                    KW_MAX'(kb_d) == ly.k && (W_MAX-1)'(fb_d) == ly.f);
    end
endmodule

// File: tb/tb_alm_mult_pipe.sv
// Directed, randomized-stream and reset checks for alm_mult_pipe (W=16, M=10),
// plus an exhaustive W=8 sweep of the shared reference against an arithmetic model.
module tb_alm_mult_pipe;
    import alm_pkg::*;

    localparam int W = 16;
    localparam int M = 10;

    typedef struct {
        logic [63:0] p;
        logic        ap;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   passes;
    int   fails;

    alm_mult_pipe_if #(.W(W)) bus ();

    alm_mult_pipe #(.W(W), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Mitchell log product with set-one adder, from plain integer arithmetic.
    function automatic logic [63:0] model(input longint unsigned a, input longint unsigned b,
                                          input bit ap, input int w, input int m);
        int ka, kb, kk;
        longint unsigned fa, fb, u, base, s, mant;
        if (!ap) return a * b;
        if (a == 0 || b == 0) return 0;
        ka = 0;
        while ((a >> (ka + 1)) != 0) ka++;
        kb = 0;
        while ((b >> (kb + 1)) != 0) kb++;
        fa   = (a - (64'd1 << ka)) << (w - 1 - ka);
        fb   = (b - (64'd1 << kb)) << (w - 1 - kb);
        u    = fa / (64'd1 << m) + fb / (64'd1 << m);
        base = 64'd1 << (w - 1 - m);
        kk   = ka + kb + ((u >= base) ? 1 : 0);
        s    = (u % base) * (64'd1 << m) + ((64'd1 << m) - 1);
        mant = (64'd1 << (w - 1)) + s;
        if (kk >= w - 1) return mant << (kk - (w - 1));
        return mant >> ((w - 1) - kk);
    endfunction

    // Drive one beat from an idle pipe and measure edges until out_valid.
    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input bit ap, input logic [31:0] exp);
        int lat;
        bus.x = a; bus.y = b; bus.approx = ap;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd3);
        check({tag, "_p_out"}, 64'(bus.p_out), 64'(exp));
        check({tag, "_p_approx"}, 64'(bus.p_approx), 64'(ap));
    endtask

    initial begin
        exp_t        q[$];
        exp_t        e;
        int          sent, got, cyc, errs;
        bit          prev_stall;
        logic [31:0] prev_p;
        logic        prev_ap;
        int          ms[2];

        total = 0; passes = 0; fails = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.approx = 1'b0; bus.out_ready = 1'b1;
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_p_out", 64'(bus.p_out), 64'd0);
        check("rst_p_approx", 64'(bus.p_approx), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        directed("soa_3x3", 16'd3, 16'd3, 1'b1, 32'd8);
        directed("exact_3x3", 16'd3, 16'd3, 1'b0, 32'd9);
        directed("soa_1x1", 16'd1, 16'd1, 1'b1, 32'd1);
        directed("soa_zero", 16'd0, 16'hFFFF, 1'b1, 32'd0);
        directed("exact_zero", 16'd0, 16'hFFFF, 1'b0, 32'd0);
        directed("soa_max", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFBFF0000);
        directed("exact_max", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);

        // Fill the pipe behind a stalled output, then reset asynchronously.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.x = 16'($urandom_range(1, 65535));
            bus.y = 16'($urandom_range(1, 65535));
            bus.approx = 1'($urandom);
            @(posedge clk); #1;
        end
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_p_out", 64'(bus.p_out), 64'd0);
        check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale_result", 64'(bus.out_valid), 64'd0);
        end
        directed("first_after_rst", 16'd5, 16'd7, 1'b0, 32'd35);
        @(posedge clk); #1;

        // Random stream with pseudo-random backpressure, scoreboarded in order.
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_p = '0; prev_ap = 1'b0;
        while (got < 64 && cyc < 3000) begin
            if (sent < 64) begin
                bus.in_valid = ($urandom_range(0, 4) != 0);
                case ($urandom_range(0, 9))
                    0:       bus.x = 16'd0;
                    1:       bus.x = 16'hFFFF;
                    default: bus.x = 16'($urandom);
                endcase
                bus.y      = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
                bus.approx = 1'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (prev_stall) begin
                check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
                check("stall_hold_p_out", 64'(bus.p_out), 64'(prev_p));
                check("stall_hold_p_approx", 64'(bus.p_approx), 64'(prev_ap));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("stream_p_out", 64'(bus.p_out), e.p);
                    check("stream_p_approx", 64'(bus.p_approx), 64'(e.ap));
                end
                got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_p     = bus.p_out;
            prev_ap    = bus.p_approx;
            if (bus.in_valid && bus.in_ready) begin
                e.p  = model(64'(bus.x), 64'(bus.y), bus.approx, W, M);
                e.ap = bus.approx;
                q.push_back(e);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("stream_results", 64'(got), 64'd64);
        check("stream_drained", 64'(q.size()), 64'd0);

        // Exhaustive W=8 sweep of the shared reference function.
        ms[0] = 0; ms[1] = 6;
        for (int mi = 0; mi < 2; mi++) begin
            errs = 0;
            for (int a = 0; a < 256; a++)
                for (int b = 0; b < 256; b++)
                    if (alm_soa_ref(32'(a), 32'(b), 8, ms[mi]) !== model(64'(a), 64'(b), 1'b1, 8, ms[mi]))
                        errs++;
            check($sformatf("exhaustive_w8_m%0d", ms[mi]), 64'(errs), 64'd0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
